// File: rtl/pf_lanectrl_pause_req_gen_if.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_pause_req_gen_if
// Groups the update-request handshake and the delay-line / pause outputs of
// the lane pause request generator.
//   UPD_REQ, UPD_CODE   : update request pulse and the code it carries
//   UPD_ACK, UPD_DROP   : completion pulse / dropped-request pulse
//   BUSY                : sequence in progress
//   HS_IO_CLK_PAUSE     : pause request to the lane pause synchroniser
//   DLY_LOAD, DLY_CODE  : delay-line load strobe and code
// master : the training/calibration side issuing requests
// slave  : the pause request generator
// -----------------------------------------------------------------------------
interface pf_lanectrl_pause_req_gen_if #(
    parameter int CODE_WIDTH = 8
) ();
    logic                  UPD_REQ;
    logic [CODE_WIDTH-1:0] UPD_CODE;
    logic                  UPD_ACK;
    logic                  UPD_DROP;
    logic                  BUSY;
    logic                  HS_IO_CLK_PAUSE;
    logic                  DLY_LOAD;
    logic [CODE_WIDTH-1:0] DLY_CODE;

    modport master (
        output UPD_REQ,
        output UPD_CODE,
        input  UPD_ACK,
        input  UPD_DROP,
        input  BUSY,
        input  HS_IO_CLK_PAUSE,
        input  DLY_LOAD,
        input  DLY_CODE
    );

    modport slave (
        input  UPD_REQ,
        input  UPD_CODE,
        output UPD_ACK,
        output UPD_DROP,
        output BUSY,
        output HS_IO_CLK_PAUSE,
        output DLY_LOAD,
        output DLY_CODE
    );
endinterface

// File: rtl/pf_lanectrl_pause_req_gen.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_pause_req_gen
// Brackets every delay-line code update with a lane clock pause request:
// pause is raised for PRE_CYCLES, the code is loaded in a single guarded
// cycle, pause is held for POST_CYCLES, then a GAP_CYCLES pause-low gap is
// enforced before the next request can be accepted so consecutive pauses
// never merge downstream.
// Ports:
//   CLK     : lane control clock, rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : slave side of pf_lanectrl_pause_req_gen_if (request handshake,
//             pause request, delay-line load strobe and code)
// -----------------------------------------------------------------------------
module pf_lanectrl_pause_req_gen #(
    parameter int                    CODE_WIDTH  = 8,
    parameter int                    PRE_CYCLES  = 2,
    parameter int                    POST_CYCLES = 2,
    parameter int                    GAP_CYCLES  = 2,
    parameter logic [CODE_WIDTH-1:0] INIT_CODE   = {CODE_WIDTH{1'b0}}
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    pf_lanectrl_pause_req_gen_if.slave  bus
);

    // Configuration errors are caught at elaboration.
    if ((PRE_CYCLES < 1) || (PRE_CYCLES > 15)) begin : g_bad_pre
        $error("pf_lanectrl_pause_req_gen: PRE_CYCLES must be in 1..15");
    end
    if ((POST_CYCLES < 1) || (POST_CYCLES > 15)) begin : g_bad_post
        $error("pf_lanectrl_pause_req_gen: POST_CYCLES must be in 1..15");
    end
    if ((GAP_CYCLES < 1) || (GAP_CYCLES > 15)) begin : g_bad_gap
        $error("pf_lanectrl_pause_req_gen: GAP_CYCLES must be in 1..15");
    end

    localparam logic [3:0] PRE_LD  = 4'(PRE_CYCLES);
    localparam logic [3:0] POST_LD = 4'(POST_CYCLES);
    localparam logic [3:0] GAP_LD  = 4'(GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_LOAD = 3'd2,
        ST_POST = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nx_s;
    logic                  accept_s;
    logic [CODE_WIDTH-1:0] hold_r;

    logic                  pause_nx_s;
    logic                  load_nx_s;
    logic                  ack_nx_s;
    logic                  drop_nx_s;
    logic                  busy_nx_s;
    logic [CODE_WIDTH-1:0] code_nx_s;

    logic                  pause_r;
    logic                  load_r;
    logic                  ack_r;
    logic                  drop_r;
    logic                  busy_r;
    logic [CODE_WIDTH-1:0] code_r;

    // State and shared down-counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Holding register: the code is sampled only when a request is accepted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_r <= INIT_CODE;
        end else if (accept_s) begin
            hold_r <= bus.UPD_CODE;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Next-state and counter logic. A count of 1 (or a stray 0) ends a phase,
    // so each timed phase lasts exactly its loaded number of cycles.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.UPD_REQ) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_PRE;
                    cnt_nx_s   = PRE_LD;
                end else begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end
            end
            ST_PRE: begin
                if (cnt_r <= 4'd1) begin
                    state_nx_s = ST_LOAD;
                    cnt_nx_s   = 4'd0;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            ST_LOAD: begin
                state_nx_s = ST_POST;
                cnt_nx_s   = POST_LD;
            end
            ST_POST: begin
                if (cnt_r <= 4'd1) begin
                    state_nx_s = ST_GAP;
                    cnt_nx_s   = GAP_LD;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_r <= 4'd1) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe in the same cycle.
    always_comb begin
        pause_nx_s = (state_nx_s == ST_PRE) || (state_nx_s == ST_LOAD) ||
                     (state_nx_s == ST_POST);
        load_nx_s  = (state_nx_s == ST_LOAD);
        ack_nx_s   = (state_r == ST_POST) && (state_nx_s == ST_GAP);
        // Anything outside IDLE, including the GAP->IDLE cycle, drops.
        drop_nx_s  = bus.UPD_REQ && (state_r != ST_IDLE);
        busy_nx_s  = (state_nx_s != ST_IDLE);
        code_nx_s  = (state_nx_s == ST_LOAD) ? hold_r : code_r;
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pause_r <= 1'b0;
            load_r  <= 1'b0;
            ack_r   <= 1'b0;
            drop_r  <= 1'b0;
            busy_r  <= 1'b0;
            code_r  <= INIT_CODE;
        end else begin
            pause_r <= pause_nx_s;
            load_r  <= load_nx_s;
            ack_r   <= ack_nx_s;
            drop_r  <= drop_nx_s;
            busy_r  <= busy_nx_s;
            code_r  <= code_nx_s;
        end
    end

    assign bus.HS_IO_CLK_PAUSE = pause_r;
    assign bus.DLY_LOAD        = load_r;
    assign bus.UPD_ACK         = ack_r;
    assign bus.UPD_DROP        = drop_r;
    assign bus.BUSY            = busy_r;
    assign bus.DLY_CODE        = code_r;

endmodule
